iopage_ctl: RTL
===============

IOPAGE_CTL -- requirements
Module: iopage_ctl

Interface
REQ-001 Parameter NDEV, default 8: number of I/O-page register blocks attached.
REQ-002 Parameter TIMEOUT, default 16: SELECT cycles without any device decode before a bus error.
REQ-003 clk  in  1  sole clock, rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 bus_addr  in  22  CPU physical byte address.
REQ-006 bus_rd, bus_wr, bus_byte_op  in  1 each  CPU read request, write request, byte qualifier.
REQ-007 bus_data_in  in  16  CPU write data.
REQ-008 bus_data_out  out  16  read data returned to the CPU.
REQ-009 bus_ack, bus_error  out  1 each  transfer complete; no device responded or request illegal.
REQ-010 iopage_addr  out  13  I/O-page offset driven to the register blocks.
REQ-011 iopage_data  out  16  write data driven to the register blocks.
REQ-012 iopage_rd, iopage_wr, iopage_byte_op  out  1 each  device strobes and byte qualifier.
REQ-013 dev_decode  in  NDEV  per-device address-match flags.
REQ-014 dev_data  in  16*NDEV  per-device read data; device i occupies bits [16i+15:16i].

Function
REQ-015 A request is an I/O-page request when bus_addr[21:13] is all ones (17760000-17777777 octal); the block ignores all other requests and raises no strobe, ack or error for them.
REQ-016 States: IDLE, SELECT, DONE, ERR.
REQ-017 IDLE: on an I/O-page request with exactly one of bus_rd/bus_wr high, the block captures bus_addr[12:0], bus_data_in, bus_byte_op and direction, clears the timeout counter, and enters SELECT next cycle.
REQ-018 IDLE: on an I/O-page request with both bus_rd and bus_wr high, the block enters ERR and issues no strobe.
REQ-019 SELECT: iopage_addr, iopage_data and iopage_byte_op are driven from the captured values; iopage_rd or iopage_wr is held high per the captured direction.
REQ-020 SELECT: if any dev_decode bit is high, the block selects the lowest-index asserted device, registers its dev_data into bus_data_out on reads, and enters DONE.
REQ-021 SELECT: if no dev_decode bit is high, the counter increments; when the counter reaches TIMEOUT-1 without a decode, the block enters ERR.
REQ-022 Each accepted write produces iopage_wr high for exactly the SELECT cycles up to and including the decode cycle, so a device sees iopage_wr && decode in exactly one cycle.
REQ-023 DONE: bus_ack is held high and iopage strobes are low; the block returns to IDLE in the cycle after bus_rd and bus_wr are both low (four-phase handshake).
REQ-024 ERR: bus_error is held high; release follows the same rule as DONE.
REQ-025 Latency: request seen in IDLE at cycle 0, strobe in cycle 1; with a decode in cycle 1, bus_ack rises in cycle 2.
REQ-026 Byte reads return the full addressed word; byte-lane selection belongs to the requester.
REQ-027 bus_data_out holds its value from the last completed read until the next completed read; writes leave it unchanged.

Reset
REQ-028 Reset forces state IDLE, counter 0, bus_ack, bus_error, iopage_rd and iopage_wr to 0, bus_data_out, iopage_addr and iopage_data to 0.
REQ-029 Reset asserted mid-transfer aborts the transfer immediately; no strobe or ack follows its release unless a new request is presented.

Structure
REQ-030 A shared package holds the state encoding, the I/O-page base constant 17760000 octal, and the 13-bit offset width.
REQ-031 The lowest-index-wins one-hot data selection is a sub-module named iopage_rdmux (NDEV-parameterised, combinational).

Verification
REQ-032 Read 17777776 with device 0 decoding and returning 000340 -> iopage_addr=17776, one-cycle iopage_rd, bus_ack in cycle 2, bus_data_out=000340.
REQ-033 Byte write of 000017 to 17777776 -> iopage_wr high exactly one cycle with iopage_byte_op=1 and iopage_data=000017, then bus_ack.
REQ-034 Read 17770000 with no device decoding -> iopage_rd held 16 cycles, then bus_error high, with no ack; dropping bus_rd returns the block to IDLE.
REQ-035 Devices 2 and 5 both decode, returning 111111 and 055555 -> bus_data_out=111111.
REQ-036 Request to 000100 -> no strobe, ack or error over 32 cycles; rd and wr both high at 17777776 -> bus_error with no strobe.
REQ-037 Reset asserted in SELECT of a write -> iopage_wr drops immediately, state IDLE, and no bus_ack after reset releases.

Source files
------------

// File: rtl/iopage_ctl_pkg.sv
// Shared definitions for the I/O-page controller.
// Contents: controller state encoding, I/O-page base address (17760000 octal),
// I/O-page offset width, and a helper that recognises I/O-page addresses.
package iopage_ctl_pkg;

  // I/O-page offset width: the page spans the top 8 KB of the 22-bit space.
  localparam int unsigned OffsetW = 13;

  // Base of the I/O page (17760000 octal).
  localparam logic [21:0] IopageBase = 22'o17760000;

  // Address bits above the offset that identify the I/O page.
  localparam logic [21-OffsetW:0] IopageTag = IopageBase[21:OffsetW];

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StSelect = 2'd1,
    StDone   = 2'd2,
    StErr    = 2'd3
  } state_e;

  // True when a 22-bit physical address falls inside the I/O page.
  function automatic logic is_iopage(input logic [21:0] addr);
    return addr[21:OffsetW] == IopageTag;
  endfunction

endpackage

// File: rtl/iopage_rdmux.sv
// Read-data selector for the I/O-page register blocks.
// Picks the data word of the lowest-index device whose decode flag is set.
// Ports:
//   decode_i  per-device address-match flags
//   data_i    packed per-device read data, device i at [16i+15:16i]
//   data_o    selected read data (zero when nothing decodes)
//   hit_o     at least one device decodes
module iopage_rdmux #(
  parameter int unsigned NDEV = 8
) (
  input  logic [NDEV-1:0]    decode_i,
  input  logic [16*NDEV-1:0] data_i,
  output logic [15:0]        data_o,
  output logic               hit_o
);

  // Walk from the highest index down so the lowest asserted index is
  // the last assignment and therefore wins.
  always_comb begin
    data_o = '0;
    for (int i = NDEV - 1; i >= 0; i--) begin
      if (decode_i[i]) begin
        data_o = data_i[16*i +: 16];
      end
    end
  end

  assign hit_o = |decode_i;

endmodule

// File: rtl/iopage_ctl.sv
// I/O-page bus controller.
// Accepts CPU requests that fall in the I/O page (17760000-17777777 octal),
// strobes the attached register blocks with the captured offset/data, and
// completes with bus_ack on a device decode or bus_error on timeout or an
// illegal simultaneous read+write. Completion is a four-phase handshake:
// ack/error stays high until the CPU drops both bus_rd and bus_wr.
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   bus_addr/rd/wr/byte_op     CPU request
//   bus_data_in/bus_data_out   CPU write data / registered read data
//   bus_ack, bus_error         completion status
//   iopage_addr/data/byte_op   captured request driven to register blocks
//   iopage_rd, iopage_wr       device strobes, high only in SELECT
//   dev_decode, dev_data       per-device match flags and read data
module iopage_ctl
  import iopage_ctl_pkg::*;
#(
  parameter int unsigned NDEV    = 8,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [21:0]          bus_addr,
  input  logic                 bus_rd,
  input  logic                 bus_wr,
  input  logic                 bus_byte_op,
  input  logic [15:0]          bus_data_in,
  output logic [15:0]          bus_data_out,
  output logic                 bus_ack,
  output logic                 bus_error,
  output logic [OffsetW-1:0]   iopage_addr,
  output logic [15:0]          iopage_data,
  output logic                 iopage_rd,
  output logic                 iopage_wr,
  output logic                 iopage_byte_op,
  input  logic [NDEV-1:0]      dev_decode,
  input  logic [16*NDEV-1:0]   dev_data
);

  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT - 1);

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic [15:0]     mux_data;
  logic            mux_hit;
  logic            req_hit;
  logic            bus_idle;

  iopage_rdmux #(
    .NDEV (NDEV)
  ) u_rdmux (
    .decode_i (dev_decode),
    .data_i   (dev_data),
    .data_o   (mux_data),
    .hit_o    (mux_hit)
  );

  assign req_hit  = is_iopage(bus_addr);
  assign bus_idle = !bus_rd && !bus_wr;

  // Single-process FSM; every output is a register. iopage_addr/data/byte_op
  // are the capture registers themselves, and iopage_rd/iopage_wr double as
  // the captured direction while in SELECT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= StIdle;
      cnt_q          <= '0;
      bus_data_out   <= '0;
      bus_ack        <= 1'b0;
      bus_error      <= 1'b0;
      iopage_addr    <= '0;
      iopage_data    <= '0;
      iopage_rd      <= 1'b0;
      iopage_wr      <= 1'b0;
      iopage_byte_op <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_hit && (bus_rd ^ bus_wr)) begin
            iopage_addr    <= bus_addr[OffsetW-1:0];
            iopage_data    <= bus_data_in;
            iopage_byte_op <= bus_byte_op;
            iopage_rd      <= bus_rd;
            iopage_wr      <= bus_wr;
            cnt_q          <= '0;
            state_q        <= StSelect;
          end else if (req_hit && bus_rd && bus_wr) begin
            // Illegal request: report without strobing any device.
            bus_error <= 1'b1;
            state_q   <= StErr;
          end
        end

        StSelect: begin
          if (mux_hit) begin
            // Byte reads still return the whole word; lane choice is the CPU's.
            if (iopage_rd) begin
              bus_data_out <= mux_data;
            end
            iopage_rd <= 1'b0;
            iopage_wr <= 1'b0;
            bus_ack   <= 1'b1;
            state_q   <= StDone;
          end else if (cnt_q == CntMax) begin
            iopage_rd <= 1'b0;
            iopage_wr <= 1'b0;
            bus_error <= 1'b1;
            state_q   <= StErr;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end

        StDone, StErr: begin
          if (bus_idle) begin
            bus_ack   <= 1'b0;
            bus_error <= 1'b0;
            state_q   <= StIdle;
          end
        end

        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
